// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver state encoding,
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchronizer for an asynchronous input.
// RST_VAL sets the value both flops take during reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RST_VAL;
      q_r    <= RST_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized line, start-bit
// glitch rejection, stop-bit framing check with recovery from a held-low line.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 78
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic                 rx_s;
  rx_state_e            state_r,   state_s;
  logic [CNT_W-1:0]     clk_cnt_r, clk_cnt_s;
  logic [IDX_W-1:0]     bit_idx_r, bit_idx_s;
  logic [DATA_BITS-1:0] shreg_r,   shreg_s;
  logic [DATA_BITS-1:0] data_r,    data_s;
  logic                 valid_r,   valid_s;
  logic                 err_r,     err_s;
  logic                 busy_r;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_rx),
    .q   (rx_s)
  );

  // Next-state, counter and datapath decode for the receive FSM
  always_comb begin
    state_s   = state_r;
    clk_cnt_s = clk_cnt_r;
    bit_idx_s = bit_idx_r;
    shreg_s   = shreg_r;
    data_s    = data_r;
    valid_s   = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      IDLE: begin
        clk_cnt_s = CNT_ZERO;
        if (!rx_s) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (clk_cnt_r == HALF) begin
          clk_cnt_s = CNT_ZERO;
          bit_idx_s = IDX_ZERO;
          // A start bit that is high again at its midpoint was a glitch
          if (!rx_s) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (clk_cnt_r == LAST) begin
          clk_cnt_s = CNT_ZERO;
          shreg_s   = {rx_s, shreg_r[DATA_BITS-1:1]};
          if (bit_idx_r == IDX_LAST) begin
            state_s = STOP;
          end else begin
            bit_idx_s = bit_idx_r + IDX_ONE;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (clk_cnt_r == LAST) begin
          clk_cnt_s = CNT_ZERO;
          if (rx_s) begin
            data_s  = shreg_r;
            valid_s = 1'b1;
            state_s = IDLE;
          end else begin
            err_s   = 1'b1;
            state_s = RECOVER;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_ONE;
        end
      end
      RECOVER: begin
        // Stay here until the line returns high so a held-low line cannot retrigger
        clk_cnt_s = CNT_ZERO;
        if (rx_s) begin
          state_s = IDLE;
        end else begin
          state_s = RECOVER;
        end
      end
      default: begin
        state_s   = IDLE;
        clk_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // State, datapath and registered output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      clk_cnt_r <= CNT_ZERO;
      bit_idx_r <= IDX_ZERO;
      shreg_r   <= {DATA_BITS{1'b0}};
      data_r    <= {DATA_BITS{1'b0}};
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      clk_cnt_r <= clk_cnt_s;
      bit_idx_r <= bit_idx_s;
      shreg_r   <= shreg_s;
      data_r    <= data_s;
      valid_r   <= valid_s;
      err_r     <= err_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  assign rx_data      = data_r;
  assign rx_valid     = valid_r;
  assign rx_frame_err = err_r;
  assign rx_busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a fast instance (8 clks/bit) for framing
// corner cases and a 78 clks/bit instance for randomized baud-tolerance traffic.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst8 = 1'b1;
  logic       rst78 = 1'b1;
  logic       ser8 = 1'b1;
  logic       ser78 = 1'b1;
  logic [7:0] data8, data78;
  logic       valid8, valid78, err8, err78, busy8, busy78;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(8)) u_rx8 (
    .clk(clk), .rst(rst8), .serial_rx(ser8),
    .rx_data(data8), .rx_valid(valid8), .rx_frame_err(err8), .rx_busy(busy8)
  );

  uart_rx #(.CLKS_PER_BIT(78)) u_rx78 (
    .clk(clk), .rst(rst78), .serial_rx(ser78),
    .rx_data(data78), .rx_valid(valid78), .rx_frame_err(err78), .rx_busy(busy78)
  );

  // Observed strobes on the fast instance
  int         v8_cnt = 0;
  int         e8_cnt = 0;
  int         busy8_cycles = 0;
  logic       prev_strobe8 = 1'b0;
  logic [7:0] got8_q[$];

  // Reference model for the slow instance: bytes sent but not yet received
  logic [7:0] exp_q[$];
  int         v78_cnt = 0;
  int         e78_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy8) busy8_cycles++;
    if (valid8 || err8) begin
      checks++;
      if ((valid8 && err8) || prev_strobe8) begin
        errors++;
        $display("FAIL strobe_shape: valid=%0b err=%0b prev=%0b", valid8, err8, prev_strobe8);
      end
    end
    if (valid8) begin
      v8_cnt++;
      got8_q.push_back(data8);
    end
    if (err8) e8_cnt++;
    prev_strobe8 = valid8 || err8;
  end

  always @(negedge clk) begin
    if (err78) e78_cnt++;
    if (valid78) begin
      v78_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rand_unexpected: got %0h expected none", data78);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data78 !== e) begin
          errors++;
          $display("FAIL rand_byte: got %0h expected %0h", data78, e);
        end
      end
    end
  end

  task automatic drive(input logic sel, input logic v, input int n);
    if (sel) ser78 = v;
    else     ser8  = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic sel, input logic [7:0] b, input logic stop_bit,
                            input int period, input int stop_len);
    drive(sel, 1'b0, period);
    for (int i = 0; i < 8; i++) drive(sel, b[i], period);
    drive(sel, stop_bit, stop_len);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int v0, e0, period;
    logic [7:0] b;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h5A, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[5] = '{8'h81, 1'b0, 0, 1, 8'hFF};
    vecs[6] = '{8'h7E, 1'b1, 1, 0, 8'h7E};

    // Reset state
    @(posedge clk); #1;
    check("rst_data", data8, 8'h00);
    check("rst_busy", busy8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b0;
    rst78 = 1'b0;
    drive(1'b0, 1'b1, 4);
    check("idle_valid", valid8, 1'b0);
    check("idle_err", err8, 1'b0);
    check("idle_busy", busy8, 1'b0);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      v0 = v8_cnt;
      e0 = e8_cnt;
      send_frame(1'b0, vecs[i].data, vecs[i].stop_bit, 8, 8);
      drive(1'b0, 1'b1, 16);
      check($sformatf("vec%0d_valid", i), v8_cnt - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_err", i), e8_cnt - e0, vecs[i].exp_err);
      check($sformatf("vec%0d_data", i), data8, vecs[i].exp_data);
      check($sformatf("vec%0d_busy", i), busy8, 1'b0);
    end

    // Start-bit glitch of two cycles
    v0 = v8_cnt; e0 = e8_cnt; busy8_cycles = 0;
    drive(1'b0, 1'b0, 2);
    drive(1'b0, 1'b1, 20);
    check("glitch_strobes", (v8_cnt - v0) + (e8_cnt - e0), 0);
    check("glitch_busy_seen", busy8_cycles > 0, 1'b1);
    check("glitch_busy_short", busy8_cycles <= 5, 1'b1);
    check("glitch_busy_end", busy8, 1'b0);

    // Framing error followed by a stuck-low line, then a good frame
    v0 = v8_cnt; e0 = e8_cnt;
    send_frame(1'b0, 8'h5A, 1'b0, 8, 8);
    drive(1'b0, 1'b0, 40);
    check("brk_err", e8_cnt - e0, 1);
    check("brk_valid", v8_cnt - v0, 0);
    check("brk_data_held", data8, 8'h7E);
    check("brk_busy_low", busy8, 1'b1);
    drive(1'b0, 1'b1, 16);
    check("brk_busy_released", busy8, 1'b0);
    check("brk_no_retrigger", e8_cnt - e0, 1);
    send_frame(1'b0, 8'h3C, 1'b1, 8, 8);
    drive(1'b0, 1'b1, 16);
    check("brk_after_data", data8, 8'h3C);
    check("brk_after_valid", v8_cnt - v0, 1);

    // Back-to-back: second start one cycle after the stop-bit midpoint
    got8_q.delete();
    send_frame(1'b0, 8'h00, 1'b1, 8, 5);
    send_frame(1'b0, 8'hFF, 1'b1, 8, 8);
    drive(1'b0, 1'b1, 16);
    check("b2b_count", got8_q.size(), 2);
    if (got8_q.size() == 2) begin
      check("b2b_first", got8_q[0], 8'h00);
      check("b2b_second", got8_q[1], 8'hFF);
    end

    // Async reset during data bit 4 of 0x96
    b = 8'h96;
    drive(1'b0, 1'b0, 8);
    for (int i = 0; i < 4; i++) drive(1'b0, b[i], 8);
    drive(1'b0, b[4], 4);
    v0 = v8_cnt; e0 = e8_cnt;
    rst8 = 1'b1;
    #1;
    check("mid_rst_data", data8, 8'h00);
    check("mid_rst_valid", valid8, 1'b0);
    check("mid_rst_err", err8, 1'b0);
    check("mid_rst_busy", busy8, 1'b0);
    drive(1'b0, 1'b1, 3);
    rst8 = 1'b0;
    drive(1'b0, 1'b1, 16);
    check("mid_rst_no_strobe", (v8_cnt - v0) + (e8_cnt - e0), 0);
    send_frame(1'b0, 8'h3C, 1'b1, 8, 8);
    drive(1'b0, 1'b1, 16);
    check("mid_rst_after", data8, 8'h3C);

    // Randomized bytes at +/- 2.5% baud error on the 78 clks/bit instance
    drive(1'b1, 1'b1, 10);
    for (int i = 0; i < 48; i++) begin
      b = 8'($urandom_range(0, 255));
      period = ($urandom_range(0, 1) == 1) ? 80 : 76;
      exp_q.push_back(b);
      send_frame(1'b1, b, 1'b1, period, period);
      drive(1'b1, 1'b1, $urandom_range(0, 20));
    end
    drive(1'b1, 1'b1, 200);
    check("rand_count", v78_cnt, 48);
    check("rand_pending", exp_q.size(), 0);
    check("rand_frame_err", e78_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
